// File: rtl/thor_pkg.sv
// Shared fetch-path definitions: datapath width, reset PC, and the
// per-request prediction metadata that travels with each fetched word.
package thor_pkg;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned PREDITOR_DEPTH = 64;
   localparam int unsigned PW             = $clog2(PREDITOR_DEPTH);
   localparam logic [XLEN-1:0] RESET_PC   = '0;

   // Prediction state captured when a request is issued
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            predTaken;
      logic [XLEN-1:0] predTarget;
      logic [PW-1:0]   predIndex;
   } fetch_meta_t;

   // One fetch-queue slot: returned instruction plus its request metadata
   typedef struct packed {
      logic [XLEN-1:0] instr;
      fetch_meta_t     meta;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy count.
// Ports: clock/reset (sync, active-high), flush clears contents,
// push/push_data write, pop/pop_data read the head (first-word fall-through),
// count = occupancy, empty = no entries. DEPTH must be a power of two >= 2.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_c, do_pop_c;

   // Next-state: a push into a full FIFO is accepted only alongside a pop
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_pop_c  = pop & (count_q != '0);
      do_push_c = push & ((count_q != CNT_W'(DEPTH)) | do_pop_c);

      if (do_push_c) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign empty    = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage behind the BPU. Holds the PC, issues in-order
// requests to instruction memory tagged with the BPU prediction, queues
// returned words with that metadata for decode, and discards responses that
// belong to requests issued before a redirect.
// Ports: clock/reset; iAddr + branchTaken/branchTarget/preditorIndex (BPU),
// bpuFlush; imemReq*/imemAddr and imemRsp* (memory); redirect/redirectPc
// (execute/commit); decValid/decReady and dec* payload (decode).
module fetch_unit #(
   parameter int unsigned             PREDITOR_DEPTH = thor_pkg::PREDITOR_DEPTH,
   parameter int unsigned             FQ_DEPTH       = 4,
   parameter logic [thor_pkg::XLEN-1:0] RESET_PC     = thor_pkg::RESET_PC
) (
   input  logic                              clock,
   input  logic                              reset,
   output logic [thor_pkg::XLEN-1:0]         iAddr,
   input  logic                              branchTaken,
   input  logic [thor_pkg::XLEN-1:0]         branchTarget,
   input  logic [$clog2(PREDITOR_DEPTH)-1:0] preditorIndex,
   output logic                              bpuFlush,
   output logic                              imemReqValid,
   input  logic                              imemReqReady,
   output logic [thor_pkg::XLEN-1:0]         imemAddr,
   input  logic                              imemRspValid,
   input  logic [thor_pkg::XLEN-1:0]         imemRspData,
   input  logic                              redirect,
   input  logic [thor_pkg::XLEN-1:0]         redirectPc,
   output logic                              decValid,
   input  logic                              decReady,
   output logic [thor_pkg::XLEN-1:0]         decInstr,
   output logic [thor_pkg::XLEN-1:0]         decPc,
   output logic                              decPredTaken,
   output logic [thor_pkg::XLEN-1:0]         decPredTarget,
   output logic [$clog2(PREDITOR_DEPTH)-1:0] decPredIndex
);

   import thor_pkg::*;

   localparam int unsigned IDX_W   = $clog2(PREDITOR_DEPTH);
   localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1;
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam int unsigned META_W  = $bits(fetch_meta_t);
   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             credit_ok_c, issue_c, rsp_c, fq_push_c, dec_pop_c;
   logic [CNT_W-1:0] fq_count, meta_count;
   logic             fq_empty, meta_empty;
   fetch_meta_t      issue_meta_c, rsp_meta;
   fetch_entry_t     fq_push_entry_c, head;

   // Credit covers queued words plus every outstanding request, stale ones included
   always_comb begin
      credit_ok_c  = (SUM_W'(fq_count) + SUM_W'(inflight_q)) < SUM_W'(FQ_DEPTH);
      imemReqValid = ~reset & ~redirect & credit_ok_c;
      issue_c      = imemReqValid & imemReqReady;
      // Responses with nothing outstanding (e.g. after reset) are ignored
      rsp_c        = imemRspValid & (inflight_q != '0);
      fq_push_c    = rsp_c & ~redirect & (drop_cnt_q == '0);
      decValid     = ~fq_empty & ~redirect;
      dec_pop_c    = decValid & decReady;
   end

   // Metadata captured at issue and joined with the word at response
   always_comb begin
      issue_meta_c.pc         = pc_q;
      issue_meta_c.predTaken  = branchTaken;
      issue_meta_c.predTarget = branchTarget;
      issue_meta_c.predIndex  = PW'(preditorIndex);
      fq_push_entry_c.instr   = imemRspData;
      fq_push_entry_c.meta    = rsp_meta;
   end

   // PC and request bookkeeping; redirect overrides everything
   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q + CNT_W'(issue_c) - CNT_W'(rsp_c);
      drop_cnt_d = drop_cnt_q;

      if (redirect) begin
         pc_d       = redirectPc & ~XLEN'(3);
         drop_cnt_d = inflight_q - CNT_W'(rsp_c);
      end else begin
         if (issue_c) begin
            pc_d = branchTaken ? branchTarget : pc_q + XLEN'(4);
         end
         if (rsp_c && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Metadata of outstanding requests, popped in response order
   sync_fifo #(
      .WIDTH (META_W),
      .DEPTH (FQ_DEPTH)
   ) u_meta_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (1'b0),
      .push      (issue_c),
      .push_data (issue_meta_c),
      .pop       (rsp_c),
      .pop_data  (rsp_meta),
      .count     (meta_count),
      .empty     (meta_empty)
   );

   // Fetched words waiting for decode; cleared on redirect
   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .push      (fq_push_c),
      .push_data (fq_push_entry_c),
      .pop       (dec_pop_c),
      .pop_data  (head),
      .count     (fq_count),
      .empty     (fq_empty)
   );

   assign iAddr         = pc_q;
   assign imemAddr      = pc_q;
   assign bpuFlush      = redirect;
   assign decInstr      = head.instr;
   assign decPc         = head.meta.pc;
   assign decPredTaken  = head.meta.predTaken;
   assign decPredTarget = head.meta.predTarget;
   assign decPredIndex  = IDX_W'(head.meta.predIndex);

   a_rsp_has_request : assert property (@(posedge clock) disable iff (reset)
      imemRspValid |-> (inflight_q != '0));

   a_meta_tracks_inflight : assert property (@(posedge clock) disable iff (reset)
      (meta_count == inflight_q) && (meta_empty == (inflight_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural in-order memory with
// programmable latency, a one-entry BPU model, and logs of issued request
// addresses and decoded entries checked against hand-computed values.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iAddr;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic [5:0]  preditorIndex;
   logic        bpuFlush;
   logic        imemReqValid;
   logic        imemReqReady;
   logic [31:0] imemAddr;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        decValid;
   logic        decReady;
   logic [31:0] decInstr;
   logic [31:0] decPc;
   logic        decPredTaken;
   logic [31:0] decPredTarget;
   logic [5:0]  decPredIndex;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
      logic [31:0] target;
      logic [5:0]  idx;
   } dec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [31:0] rq[$];
   dec_t        dq[$];

   int          cyc = 0;
   int          lat = 1;
   logic        bpu_en = 1'b0;
   logic [31:0] bpu_pc = 32'h10;
   logic [31:0] bpu_tgt = 32'h80;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n;
   dec_t        e;

   fetch_unit dut (
      .clock         (clk),
      .reset         (reset),
      .iAddr         (iAddr),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .preditorIndex (preditorIndex),
      .bpuFlush      (bpuFlush),
      .imemReqValid  (imemReqValid),
      .imemReqReady  (imemReqReady),
      .imemAddr      (imemAddr),
      .imemRspValid  (imemRspValid),
      .imemRspData   (imemRspData),
      .redirect      (redirect),
      .redirectPc    (redirectPc),
      .decValid      (decValid),
      .decReady      (decReady),
      .decInstr      (decInstr),
      .decPc         (decPc),
      .decPredTaken  (decPredTaken),
      .decPredTarget (decPredTarget),
      .decPredIndex  (decPredIndex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   function automatic dec_t dq_at(input int i);
      dec_t r;
      r = '{pc: 32'hDEADBEEF, instr: 32'hDEADBEEF, taken: 1'b0, target: 32'hDEADBEEF, idx: 6'h3F};
      if (i < dq.size()) r = dq[i];
      return r;
   endfunction

   function automatic logic [31:0] rq_at(input int i);
      logic [31:0] r;
      r = 32'hDEADBEEF;
      if (i < rq.size()) r = rq[i];
      return r;
   endfunction

   // Leaves reset asserted; caller releases it
   task automatic apply_reset();
      reset        = 1'b1;
      redirect     = 1'b0;
      redirectPc   = '0;
      decReady     = 1'b1;
      imemReqReady = 1'b1;
      bpu_en       = 1'b0;
      tick(2);
      rq.delete();
      dq.delete();
   endtask

   initial begin : cycle_count
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory, BPU and logging; each phase sits at a fixed offset after negedge
   initial begin : env_model
      imemRspValid  = 1'b0;
      imemRspData   = '0;
      branchTaken   = 1'b0;
      branchTarget  = '0;
      preditorIndex = '0;
      forever begin
         @(negedge clk);
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            imemRspValid = 1'b1;
            imemRspData  = ~pend[0].addr;
            void'(pend.pop_front());
         end else begin
            imemRspValid = 1'b0;
            imemRspData  = '0;
         end
         #1;
         branchTaken   = bpu_en && (iAddr == bpu_pc);
         branchTarget  = branchTaken ? bpu_tgt : 32'h0;
         preditorIndex = iAddr[7:2];
         #2;
         if (reset) begin
            pend.delete();
         end else begin
            if (imemReqValid && imemReqReady) begin
               pend.push_back('{addr: imemAddr, due: cyc + 1 + lat});
               rq.push_back(imemAddr);
            end
            if (decValid && decReady)
               dq.push_back('{pc: decPc, instr: decInstr, taken: decPredTaken,
                              target: decPredTarget, idx: decPredIndex});
         end
      end
   end

   initial begin : stim
      reset        = 1'b1;
      redirect     = 1'b0;
      redirectPc   = '0;
      decReady     = 1'b1;
      imemReqReady = 1'b1;

      // Reset state and sequential fetch
      apply_reset();
      #2;
      check("rst_reqvalid", 32'(imemReqValid), 32'd0);
      check("rst_decvalid", 32'(decValid), 32'd0);
      check("rst_bpuflush", 32'(bpuFlush), 32'd0);
      check("rst_iaddr", iAddr, 32'h0);
      lat   = 1;
      reset = 1'b0;
      tick(8);
      for (int i = 0; i < 4; i++) begin
         e = dq_at(i);
         check($sformatf("seq_req%0d", i), rq_at(i), 32'(i * 4));
         check($sformatf("seq_decpc%0d", i), e.pc, 32'(i * 4));
         check($sformatf("seq_instr%0d", i), e.instr, ~32'(i * 4));
         check($sformatf("seq_taken%0d", i), 32'(e.taken), 32'd0);
      end

      // Predicted-taken branch at 0x10
      apply_reset();
      bpu_en = 1'b1;
      reset  = 1'b0;
      tick(10);
      check("bpu_req_after_hit", rq_at(5), 32'h80);
      e = dq_at(4);
      check("bpu_hit_pc", e.pc, 32'h10);
      check("bpu_hit_taken", 32'(e.taken), 32'd1);
      check("bpu_hit_target", e.target, 32'h80);
      check("bpu_hit_index", 32'(e.idx), 32'd4);
      e = dq_at(3);
      check("bpu_prev_taken", 32'(e.taken), 32'd0);
      e = dq_at(5);
      check("bpu_tgt_decpc", e.pc, 32'h80);

      // Credit limit with decode stalled
      apply_reset();
      decReady = 1'b0;
      reset    = 1'b0;
      tick(8);
      #2;
      check("credit_reqs", 32'(rq.size()), 32'd4);
      check("credit_reqvalid", 32'(imemReqValid), 32'd0);
      check("credit_decvalid", 32'(decValid), 32'd1);
      check("credit_head_pc", decPc, 32'h0);
      decReady = 1'b1;
      tick(1);
      decReady = 1'b0;
      tick(3);
      #2;
      check("credit_reqs_after_pop", 32'(rq.size()), 32'd5);
      check("credit_new_addr", rq_at(4), 32'h10);
      check("credit_reqvalid_again", 32'(imemReqValid), 32'd0);
      check("credit_pops", 32'(dq.size()), 32'd1);

      // Redirect with three requests in flight, 4-cycle memory
      apply_reset();
      lat   = 4;
      reset = 1'b0;
      tick(3);
      check("redir_inflight_reqs", 32'(rq.size()), 32'd3);
      redirect   = 1'b1;
      redirectPc = 32'h203;
      #2;
      check("redir_bpuflush_on", 32'(bpuFlush), 32'd1);
      check("redir_no_issue", 32'(imemReqValid), 32'd0);
      tick(1);
      redirect = 1'b0;
      #2;
      check("redir_bpuflush_off", 32'(bpuFlush), 32'd0);
      check("redir_pc_aligned", iAddr, 32'h200);
      tick(20);
      check("redir_req_addr", rq_at(3), 32'h200);
      e = dq_at(0);
      check("redir_first_decpc", e.pc, 32'h200);
      check("redir_first_instr", e.instr, ~32'h200);
      e = dq_at(1);
      check("redir_second_decpc", e.pc, 32'h204);

      // Redirect coincident with a response and a decode pop
      apply_reset();
      lat   = 1;
      reset = 1'b0;
      tick(4);
      #1;
      check("coinc_pre_decvalid", 32'(decValid), 32'd1);
      check("coinc_pre_rsp", 32'(imemRspValid), 32'd1);
      n          = dq.size();
      redirect   = 1'b1;
      redirectPc = 32'h400;
      #1;
      check("coinc_decvalid_forced", 32'(decValid), 32'd0);
      tick(1);
      redirect = 1'b0;
      #2;
      check("coinc_no_pop", 32'(dq.size()), 32'(n));
      check("coinc_queue_empty", 32'(decValid), 32'd0);
      tick(6);
      e = dq_at(n);
      check("coinc_next_decpc", e.pc, 32'h400);

      // PC wrap at top of address space
      apply_reset();
      lat   = 1;
      reset = 1'b0;
      tick(2);
      n          = rq.size();
      redirect   = 1'b1;
      redirectPc = 32'hFFFF_FFFC;
      tick(1);
      redirect = 1'b0;
      #2;
      check("wrap_pc_top", iAddr, 32'hFFFF_FFFC);
      tick(1);
      #2;
      check("wrap_pc_zero", iAddr, 32'h0);
      tick(3);
      check("wrap_req_top", rq_at(n), 32'hFFFF_FFFC);
      check("wrap_req_zero", rq_at(n + 1), 32'h0);

      // Reset in the middle of a burst
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      #2;
      check("midrst_decvalid", 32'(decValid), 32'd0);
      check("midrst_pc", iAddr, 32'h0);
      check("midrst_reqvalid", 32'(imemReqValid), 32'd1);
      n = dq.size();
      tick(5);
      e = dq_at(n);
      check("midrst_first_decpc", e.pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
